// File: rtl/z16_pkg.sv
// Shared Z16 encoder definitions: opcodes, error codes, FSM states, tuple type.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package z16_pkg;

    // Opcode map. 0x0-0x8 are three-register ALU forms.
    localparam logic [3:0] OP_LI  = 4'h9;   // load immediate, 8-bit imm
    localparam logic [3:0] OP_LD  = 4'hA;   // load, 4-bit offset
    localparam logic [3:0] OP_ST  = 4'hB;   // store, 4-bit offset in rd slot
    localparam logic [3:0] OP_BR0 = 4'hC;   // branch, 4-bit offset
    localparam logic [3:0] OP_BR1 = 4'hD;   // branch, 4-bit offset
    localparam logic [3:0] OP_BR2 = 4'hE;   // compare-branch, 8-bit offset, 2-bit regs
    localparam logic [3:0] OP_BR3 = 4'hF;   // compare-branch, 8-bit offset, 2-bit regs

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_IMM_RANGE = 2'd1;
    localparam logic [1:0] ERR_REG_RANGE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [15:0] imm;
    } tuple_t;

    // True when imm equals the sign extension of its low 8 bits.
    function automatic logic imm_fits8(input logic [15:0] imm);
        return imm[15:7] == {9{imm[7]}};
    endfunction

    // True when imm equals the sign extension of its low 4 bits.
    function automatic logic imm_fits4(input logic [15:0] imm);
        return imm[15:3] == {13{imm[3]}};
    endfunction

endpackage

// File: rtl/z16_instr_encoder_if.sv
// Z16 encoder bus: program control, field-tuple handshake, memory write port, status.
// Latency: n/a (wires only).
// Backpressure: o_ready on tuples, i_mem_ready on memory writes.
// Ports: slave = encoder view, master = driver/memory/monitor view.
interface z16_instr_encoder_if;
    logic        i_start;
    logic [15:0] i_base_addr;
    logic        i_valid;
    logic        o_ready;
    logic        i_last;
    logic [3:0]  i_opcode;
    logic [3:0]  i_rd;
    logic [3:0]  i_rs1;
    logic [3:0]  i_rs2;
    logic [15:0] i_imm;
    logic        o_mem_wen;
    logic [15:0] o_mem_addr;
    logic [15:0] o_mem_wdata;
    logic        i_mem_ready;
    logic        o_err;
    logic [1:0]  o_err_code;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_count;

    modport slave (
        input  i_start, i_base_addr, i_valid, i_last,
        input  i_opcode, i_rd, i_rs1, i_rs2, i_imm, i_mem_ready,
        output o_ready, o_mem_wen, o_mem_addr, o_mem_wdata,
        output o_err, o_err_code, o_busy, o_done, o_count
    );

    modport master (
        output i_start, i_base_addr, i_valid, i_last,
        output i_opcode, i_rd, i_rs1, i_rs2, i_imm, i_mem_ready,
        input  o_ready, o_mem_wen, o_mem_addr, o_mem_wdata,
        input  o_err, o_err_code, o_busy, o_done, o_count
    );
endinterface

// File: rtl/z16_instr_pack.sv
// Packs one field tuple into a 16-bit Z16 instruction word and range-checks it.
// Latency: combinational.
// Backpressure: none.
// Ports: tuple in (opcode/rd/rs1/rs2/imm); word out; err_code out (ERR_NONE when legal).
module z16_instr_pack
    import z16_pkg::*;
(
    input  tuple_t      tuple,
    output logic [15:0] word,
    output logic [1:0]  err_code
);

    always_comb begin
        word     = {tuple.rs2, tuple.rs1, tuple.rd, tuple.opcode};
        err_code = ERR_NONE;
        case (tuple.opcode)
            OP_LI: begin
                word = {tuple.imm[7:0], tuple.rd, tuple.opcode};
                if (!imm_fits8(tuple.imm)) err_code = ERR_IMM_RANGE;
            end
            OP_LD, OP_BR0, OP_BR1: begin
                word = {tuple.imm[3:0], tuple.rs1, tuple.rd, tuple.opcode};
                if (!imm_fits4(tuple.imm)) err_code = ERR_IMM_RANGE;
            end
            OP_ST: begin
                word = {tuple.rs2, tuple.rs1, tuple.imm[3:0], tuple.opcode};
                if (!imm_fits4(tuple.imm)) err_code = ERR_IMM_RANGE;
            end
            OP_BR2, OP_BR3: begin
                // Only two bits per register fit; immediate error wins over register error.
                word = {tuple.imm[7:0], tuple.rs2[1:0], tuple.rs1[1:0], tuple.opcode};
                if (!imm_fits8(tuple.imm))
                    err_code = ERR_IMM_RANGE;
                else if ((tuple.rs1 > 4'd3) || (tuple.rs2 > 4'd3))
                    err_code = ERR_REG_RANGE;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/z16_instr_encoder.sv
// Streams field tuples into packed Z16 words written to consecutive memory addresses.
// Latency: tuple accept -> o_mem_wen one cycle later (one-entry output stage).
// Backpressure: o_ready drops while the staged word waits on i_mem_ready; words never dropped.
// Ports: i_clk, i_rst_n (async active-low), bus (z16_instr_encoder_if.slave).
module z16_instr_encoder
    import z16_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    z16_instr_encoder_if.slave    bus
);

    state_t      state;
    logic        stage_vld;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] count_q;
    logic        err_q;
    logic [1:0]  err_code_q;
    logic        busy_q;
    logic        done_q;

    tuple_t      tuple;
    logic [15:0] pack_word;
    logic [1:0]  pack_err;
    logic        accept;
    logic        write_done;

    assign tuple = '{opcode: bus.i_opcode, rd: bus.i_rd, rs1: bus.i_rs1,
                     rs2: bus.i_rs2, imm: bus.i_imm};

    z16_instr_pack u_pack (
        .tuple    (tuple),
        .word     (pack_word),
        .err_code (pack_err)
    );

    // A new tuple may enter when the stage is empty or is being emptied this cycle.
    assign bus.o_ready = (state == ST_RUN) && (!stage_vld || bus.i_mem_ready);
    assign accept      = bus.i_valid && bus.o_ready;
    assign write_done  = stage_vld && bus.i_mem_ready;

    assign bus.o_mem_wen   = stage_vld;
    assign bus.o_mem_addr  = addr_q;
    assign bus.o_mem_wdata = wdata_q;
    assign bus.o_count     = count_q;
    assign bus.o_err       = err_q;
    assign bus.o_err_code  = err_code_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_done      = done_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            stage_vld  <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;

            // addr_q always points at the staged word, or the next free slot.
            if (write_done) begin
                addr_q <= addr_q + 16'd1;
                if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
            end

            if (accept) begin
                if (pack_err != ERR_NONE) begin
                    err_q      <= 1'b1;
                    err_code_q <= pack_err;
                    stage_vld  <= 1'b0;
                end else begin
                    stage_vld <= 1'b1;
                    wdata_q   <= pack_word;
                end
            end else if (write_done) begin
                stage_vld <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        state   <= ST_RUN;
                        busy_q  <= 1'b1;
                        addr_q  <= bus.i_base_addr;
                        count_q <= '0;
                    end
                end
                ST_RUN: begin
                    // A rejected final tuple still ends the program.
                    if (accept && bus.i_last) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!stage_vld || bus.i_mem_ready) begin
                        state  <= ST_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/z16_instr_encoder.md
Z16_INSTR_ENCODER -- requirements
Module: z16_instr_encoder

Interface
REQ-001 SHALL have ports: i_clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: i_rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: i_start  in  1  begin program load; i_base_addr  in  16  first write address.
REQ-004 SHALL have ports: i_valid  in  1 / o_ready  out  1  field-tuple handshake; i_last  in  1  final tuple of program.
REQ-005 SHALL have ports: i_opcode  in  4; i_rd, i_rs1, i_rs2  in  4 each; i_imm  in  16  signed immediate.
REQ-006 SHALL have ports: o_mem_wen  out  1; o_mem_addr  out  16; o_mem_wdata  out  16; i_mem_ready  in  1  write accepted.
REQ-007 SHALL have ports: o_err  out  1 pulse; o_err_code  out  2; o_busy  out  1; o_done  out  1 pulse; o_count  out  16  words written.

Function
REQ-010 SHALL run FSM IDLE -> RUN (i_start) -> DRAIN (last tuple accepted) -> DONE (stage empty) -> IDLE after exactly one cycle.
REQ-011 SHALL load the address counter with i_base_addr and clear o_count on i_start in IDLE; i_start outside IDLE SHALL be ignored.
REQ-012 SHALL drive o_ready = (state==RUN) && (!stage_valid || i_mem_ready).
REQ-013 SHALL accept a tuple on i_valid && o_ready and register its encoding into a one-entry output stage; latency accept -> o_mem_wen = 1 cycle.
REQ-014 SHALL encode bits [3:0]=opcode for all opcodes.
REQ-015 SHALL encode opcodes 0x0-0x8 as [15:12]=rs2, [11:8]=rs1, [7:4]=rd.
REQ-016 SHALL encode 0x9 as [15:8]=imm[7:0], [7:4]=rd; i_rs1 ignored.
REQ-017 SHALL encode 0xA, 0xC, 0xD as [15:12]=imm[3:0], [11:8]=rs1, [7:4]=rd.
REQ-018 SHALL encode 0xB as [15:12]=rs2, [11:8]=rs1, [7:4]=imm[3:0].
REQ-019 SHALL encode 0xE, 0xF as [15:8]=imm[7:0], [7:6]=rs2[1:0], [5:4]=rs1[1:0].
REQ-020 SHALL flag IMM_RANGE (2'd1) when i_imm is not the sign extension of its low 8 bits (0x9, 0xE, 0xF) or low 4 bits (0xA-0xD).
REQ-021 SHALL flag REG_RANGE (2'd2) when rs1 or rs2 > 3 for 0xE/0xF; IMM_RANGE takes priority when both apply.
REQ-022 SHALL, for a flagged tuple, write nothing, pulse o_err for one cycle in the cycle after acceptance, and hold o_err_code until the next error or reset.
REQ-023 SHALL hold o_mem_wen/addr/wdata stable while i_mem_ready is low; on wen && i_mem_ready increment address and o_count.
REQ-024 SHALL wrap o_mem_addr 0xFFFF -> 0x0000 without error; o_count saturates at 0xFFFF.
REQ-025 SHALL treat a flagged tuple with i_last as still ending the program (enter DRAIN).
REQ-026 SHALL drive o_busy high in RUN and DRAIN; o_done high only in DONE.

Reset
REQ-030 SHALL on i_rst_n low immediately force state IDLE, stage_valid 0, o_mem_wen 0, o_mem_addr 0, o_mem_wdata 0, o_err 0, o_err_code 0, o_count 0, o_done 0, o_busy 0, o_ready 0.
REQ-031 SHALL discard any pending staged word when reset asserts mid-RUN; no write occurs after reset release until a new i_start.

Structure
REQ-040 SHALL take opcode constants (OP_LI=0x9, OP_LD=0xA, OP_ST=0xB, OP_BR*=0xC-0xF), error-code constants and FSM state typedef from shared package z16_pkg.
REQ-041 SHALL place packing and range checks in combinational sub-module z16_instr_pack; FSM, stage register, counters in the top.

Verification
REQ-050 SHALL verify: start base=0x0100, op=0x1 rd=3 rs1=4 rs2=5 -> wen at 0x0100 data 0x5431 one cycle after accept.
REQ-051 SHALL verify: op=0x9 rd=2 imm=0xFF80 -> data 0x8029; then imm=0x0080 -> o_err pulse, code 1, no write, address unchanged.
REQ-052 SHALL verify: op=0xB rs1=1 rs2=2 imm=0xFFFF -> 0x21FB; op=0xF rs1=1 rs2=2 imm=0x0010 -> 0x109F; op=0xE rs1=5 -> code 2.
REQ-053 SHALL verify: i_mem_ready low 3 cycles with stage full -> o_ready low, outputs stable, no tuple lost; 4-tuple program ends with o_done pulse, o_count=4.
REQ-054 SHALL verify: base=0xFFFF, two tuples -> writes at 0xFFFF then 0x0000.
REQ-055 SHALL verify: reset asserted with staged word and i_mem_ready low -> all outputs zero same cycle, no write after release.
